// File: rtl/axis_upsizer_strb.sv
// axis_upsizer_strb: AXI-Stream width upsizer. Packs RATIO consecutive slave
// beats into one wide master word. A packet ending on a partial word emits a
// short word whose TSTRB marks only the filled byte lanes. SRCDEST is
// captured with the first beat of each word and presented on M_AXIS_TUSER.
//
// Optional build macro: AXIS_UPSIZER_TKEEP_IN_EN adds S_AXIS_TKEEP. Each
// written lane then takes its strobes from TKEEP, and data bytes whose
// TKEEP bit is 0 are zeroed. Without the macro, every written lane gets
// all strobes set.
//
// Handshake: a beat transfers on an edge where TVALID and TREADY are both
// high. A master word, once valid, holds every field stable and keeps
// TVALID high until M_AXIS_TREADY accepts it. The slave side is ready
// whenever the output register is empty or is draining in the same cycle.
module axis_upsizer_strb #(
  parameter int S_DATA_WIDTH = 32,
  parameter int RATIO        = 2,
  parameter int USER_WIDTH   = 32,
  parameter int LANE_ORDER   = 0
) (
  input  logic                             AXIS_ACLK,
  input  logic                             AXIS_ARESET,
  input  logic                             S_AXIS_TVALID,
  output logic                             S_AXIS_TREADY,
  input  logic [S_DATA_WIDTH-1:0]          S_AXIS_TDATA,
`ifdef AXIS_UPSIZER_TKEEP_IN_EN
  input  logic [S_DATA_WIDTH/8-1:0]        S_AXIS_TKEEP,
`endif
  input  logic                             S_AXIS_TLAST,
  input  logic [USER_WIDTH-1:0]            SRCDEST,
  output logic                             M_AXIS_TVALID,
  input  logic                             M_AXIS_TREADY,
  output logic [S_DATA_WIDTH*RATIO-1:0]    M_AXIS_TDATA,
  output logic [S_DATA_WIDTH*RATIO/8-1:0]  M_AXIS_TSTRB,
  output logic                             M_AXIS_TLAST,
  output logic [USER_WIDTH-1:0]            M_AXIS_TUSER
);

  localparam int S_BYTES = S_DATA_WIDTH / 8;
  localparam int M_WIDTH = S_DATA_WIDTH * RATIO;
  localparam int M_BYTES = M_WIDTH / 8;
  localparam int LANE_W  = $clog2(RATIO);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [LANE_W-1:0]       lane;
  logic [LANE_W-1:0]       phys;
  logic [M_WIDTH-1:0]      data_q;
  logic [M_BYTES-1:0]      strb_q;
  logic                    last_q;
  logic [USER_WIDTH-1:0]   user_q;
  logic                    valid_q;

  logic                    accept;
  logic                    word_done;
  logic [S_DATA_WIDTH-1:0] beat_data;
  logic [S_BYTES-1:0]      beat_strb;
  logic [M_WIDTH-1:0]      data_n;
  logic [M_BYTES-1:0]      strb_n;

  assign S_AXIS_TREADY = !AXIS_ARESET && (!valid_q || M_AXIS_TREADY);
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign word_done     = accept && ((lane == LAST_LANE) || S_AXIS_TLAST);

  assign M_AXIS_TVALID = valid_q;
  assign M_AXIS_TDATA  = data_q;
  assign M_AXIS_TSTRB  = strb_q;
  assign M_AXIS_TLAST  = last_q;
  assign M_AXIS_TUSER  = user_q;

  // Incoming beat after optional byte masking, and the strobes for its lane.
  always_comb begin
    beat_data = S_AXIS_TDATA;
    beat_strb = '1;
`ifdef AXIS_UPSIZER_TKEEP_IN_EN
    beat_strb = S_AXIS_TKEEP;
    for (int b = 0; b < S_BYTES; b++) begin
      if (!S_AXIS_TKEEP[b]) beat_data[b*8 +: 8] = 8'h00;
    end
`endif
  end

  // Map the logical lane counter onto a physical lane of the wide word.
  always_comb begin
    if (LANE_ORDER != 0) phys = LAST_LANE - lane;
    else                 phys = lane;
  end

  // Next contents of the output register: the first beat of a word starts
  // from all-zero data and strobes so unfilled lanes of a short word read 0.
  always_comb begin
    data_n = (lane == '0) ? '0 : data_q;
    strb_n = (lane == '0) ? '0 : strb_q;
    for (int i = 0; i < RATIO; i++) begin
      if (phys == LANE_W'(i)) begin
        data_n[i*S_DATA_WIDTH +: S_DATA_WIDTH] = beat_data;
        strb_n[i*S_BYTES +: S_BYTES]           = beat_strb;
      end
    end
  end

  // Lane counter, output register and valid flag.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      lane    <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (valid_q && M_AXIS_TREADY) valid_q <= 1'b0;
      if (accept) begin
        data_q <= data_n;
        strb_q <= strb_n;
        if (lane == '0) user_q <= SRCDEST;
        if (word_done) begin
          valid_q <= 1'b1;
          last_q  <= S_AXIS_TLAST;
          lane    <= '0;
        end else begin
          lane    <= lane + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_upsizer_strb.sv
// tb_axis_upsizer_strb: scoreboard bench for axis_upsizer_strb. A default
// instance (32-bit, ratio 2, LSB-first) takes directed and random packets;
// a second instance (16-bit, ratio 4, MSB-first) takes directed words.
module tb_axis_upsizer_strb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT 1: defaults ----------------
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic [31:0] srcdest = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic [7:0]  m_strb;
  logic        m_last;
  logic [31:0] m_user;

  axis_upsizer_strb u_dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .S_AXIS_TVALID (s_valid),
    .S_AXIS_TREADY (s_ready),
    .S_AXIS_TDATA  (s_data),
    .S_AXIS_TLAST  (s_last),
    .SRCDEST       (srcdest),
    .M_AXIS_TVALID (m_valid),
    .M_AXIS_TREADY (m_ready),
    .M_AXIS_TDATA  (m_data),
    .M_AXIS_TSTRB  (m_strb),
    .M_AXIS_TLAST  (m_last),
    .M_AXIS_TUSER  (m_user)
  );

  // ---------------- DUT 2: 16-bit, ratio 4, MSB-first ----------------
  logic        d2_s_valid = 1'b0;
  logic        d2_s_ready;
  logic [15:0] d2_s_data = '0;
  logic        d2_s_last = 1'b0;
  logic [7:0]  d2_srcdest = '0;
  logic        d2_m_valid;
  logic        d2_m_ready = 1'b1;
  logic [63:0] d2_m_data;
  logic [7:0]  d2_m_strb;
  logic        d2_m_last;
  logic [7:0]  d2_m_user;

  axis_upsizer_strb #(
    .S_DATA_WIDTH (16),
    .RATIO        (4),
    .USER_WIDTH   (8),
    .LANE_ORDER   (1)
  ) u_dut2 (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .S_AXIS_TVALID (d2_s_valid),
    .S_AXIS_TREADY (d2_s_ready),
    .S_AXIS_TDATA  (d2_s_data),
    .S_AXIS_TLAST  (d2_s_last),
    .SRCDEST       (d2_srcdest),
    .M_AXIS_TVALID (d2_m_valid),
    .M_AXIS_TREADY (d2_m_ready),
    .M_AXIS_TDATA  (d2_m_data),
    .M_AXIS_TSTRB  (d2_m_strb),
    .M_AXIS_TLAST  (d2_m_last),
    .M_AXIS_TUSER  (d2_m_user)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic rand_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [63:0] exp_data_q[$];
  logic [7:0]  exp_strb_q[$];
  logic        exp_last_q[$];
  logic [31:0] exp_user_q[$];

  logic [31:0] pk_d[8];
  logic [31:0] pk_u[8];

  // Split a packet of n beats into words of two beats; beat k of a word sits
  // at bit offset 32*k, a short final word has its upper half empty.
  task automatic push_packet(input int n);
    logic [63:0] d;
    logic [7:0]  s;
    for (int w = 0; w * 2 < n; w++) begin
      d = '0;
      s = '0;
      for (int k = 0; k < 2 && (w * 2 + k) < n; k++) begin
        d = d | (64'(pk_d[w*2+k]) << (32 * k));
        s = s | (8'h0F << (4 * k));
      end
      exp_data_q.push_back(d);
      exp_strb_q.push_back(s);
      exp_last_q.push_back((w * 2 + 2) >= n);
      exp_user_q.push_back(pk_u[w*2]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present one beat and return just after the edge that accepted it.
  task automatic send_beat(input logic [31:0] d, input logic last, input logic [31:0] u);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    srcdest = u;
    @(negedge clk);
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready stayed low for %0d cycles", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_packet(input int n);
    push_packet(n);
    for (int k = 0; k < n; k++) send_beat(pk_d[k], k == n - 1, pk_u[k]);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic d2_beat(input logic [15:0] d, input logic last, input logic [7:0] u);
    chk("d2_s_ready", 64'(d2_s_ready), 64'd1);
    d2_s_valid = 1'b1;
    d2_s_data  = d;
    d2_s_last  = last;
    d2_srcdest = u;
    @(posedge clk);
    #1;
    d2_s_valid = 1'b0;
    d2_s_last  = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (exp_data_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_queue_empty", 64'(exp_data_q.size()), 64'd0);
    #1;
  endtask

  // Random downstream backpressure while rand_mode is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  logic        held = 1'b0;
  logic [63:0] held_data;
  logic [7:0]  held_strb;
  logic        held_last;
  logic [31:0] held_user;

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", m_data, held_data);
        chk("stall_strb", 64'(m_strb), 64'(held_strb));
        chk("stall_last", 64'(m_last), 64'(held_last));
        chk("stall_user", 64'(m_user), 64'(held_user));
      end
      held = m_valid && !m_ready;
      held_data = m_data;
      held_strb = m_strb;
      held_last = m_last;
      held_user = m_user;
      if (m_valid && m_ready) begin
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: data %h with empty queue", m_data);
        end else begin
          chk("word_data", m_data, exp_data_q.pop_front());
          chk("word_strb", 64'(m_strb), 64'(exp_strb_q.pop_front()));
          chk("word_last", 64'(m_last), 64'(exp_last_q.pop_front()));
          chk("word_user", 64'(m_user), 64'(exp_user_q.pop_front()));
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  int plen;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_m_strb", 64'(m_strb), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_user", 64'(m_user), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;

    // Second instance: MSB-first lane order, short and full words.
    d2_beat(16'h1111, 1'b0, 8'h77);
    d2_beat(16'h2222, 1'b0, 8'h01);
    d2_beat(16'h3333, 1'b1, 8'h02);
    chk("d2_valid", 64'(d2_m_valid), 64'd1);
    chk("d2_data_short", d2_m_data, 64'h1111222233330000);
    chk("d2_strb_short", 64'(d2_m_strb), 64'hFC);
    chk("d2_last_short", 64'(d2_m_last), 64'd1);
    chk("d2_user_short", 64'(d2_m_user), 64'h77);
    d2_beat(16'hAAAA, 1'b0, 8'h12);
    d2_beat(16'hBBBB, 1'b0, 8'h13);
    d2_beat(16'hCCCC, 1'b0, 8'h14);
    d2_beat(16'hDDDD, 1'b0, 8'h15);
    chk("d2_data_full", d2_m_data, 64'hAAAABBBBCCCCDDDD);
    chk("d2_strb_full", 64'(d2_m_strb), 64'hFF);
    chk("d2_last_full", 64'(d2_m_last), 64'd0);
    chk("d2_user_full", 64'(d2_m_user), 64'h12);
    d2_beat(16'hEEEE, 1'b1, 8'h34);
    chk("d2_data_one", d2_m_data, 64'hEEEE000000000000);
    chk("d2_strb_one", 64'(d2_m_strb), 64'hC0);
    chk("d2_last_one", 64'(d2_m_last), 64'd1);
    chk("d2_user_one", 64'(d2_m_user), 64'h34);
    @(posedge clk);
    #1;
    chk("d2_valid_drop", 64'(d2_m_valid), 64'd0);

    // Full two-beat packet; word valid right after the completing beat.
    pk_d[0] = 32'h11111111; pk_u[0] = 32'h0;
    pk_d[1] = 32'h22222222; pk_u[1] = 32'h0;
    run_packet(2);
    chk("latency_full", 64'(m_valid), 64'd1);
    wait_drained();

    // Three-beat packet: full word then short word.
    pk_d[0] = 32'hA; pk_u[0] = 32'h1;
    pk_d[1] = 32'hB; pk_u[1] = 32'h2;
    pk_d[2] = 32'hC; pk_u[2] = 32'h3;
    run_packet(3);
    chk("latency_short", 64'(m_valid), 64'd1);
    wait_drained();

    // SRCDEST comes from the first beat of the word.
    pk_d[0] = 32'hDEAD0001; pk_u[0] = 32'h5;
    pk_d[1] = 32'hDEAD0002; pk_u[1] = 32'h9;
    run_packet(2);
    wait_drained();

    // Downstream stall with continuous slave valid.
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pk_d[k] = $urandom;
      pk_u[k] = $urandom;
    end
    fork
      run_packet(6);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("stall_word_seen", 64'(m_valid), 64'd1);
        repeat (5) begin
          @(negedge clk);
          chk("stall_s_ready", 64'(s_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_drained();

    // Reset mid-word discards the partial word.
    send_beat(32'h55, 1'b0, 32'h0);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_m_data", m_data, 64'd0);
    chk("mid_rst_m_strb", 64'(m_strb), 64'd0);
    chk("mid_rst_m_user", 64'(m_user), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    pk_d[0] = 32'h33; pk_u[0] = 32'h0;
    pk_d[1] = 32'h44; pk_u[1] = 32'h0;
    run_packet(2);
    wait_drained();

    // Random packets with random gaps and random backpressure.
    rand_mode = 1'b1;
    for (int p = 0; p < 100; p++) begin
      plen = $urandom_range(1, 7);
      for (int k = 0; k < plen; k++) begin
        pk_d[k] = $urandom;
        pk_u[k] = $urandom;
      end
      push_packet(plen);
      for (int k = 0; k < plen; k++) begin
        send_beat(pk_d[k], k == plen - 1, pk_u[k]);
        if ($urandom_range(0, 3) == 0) begin
          s_valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    rand_mode = 1'b0;
    m_ready = 1'b1;
    wait_drained();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
